// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the instruction dispatch engine.
package dispatch_pkg;

    typedef enum logic [0:0] {
        ROUTE_TAG = 1'b0,
        ROUTE_RR  = 1'b1
    } route_mode_e;

    // Bits needed to name one of n cores (at least one bit).
    function automatic int unsigned cid_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with flush; full/empty from wrap-bit pointers.
module sync_fifo #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         w_en,
    input  logic [DATA_SIZE-1:0]         w_data,
    input  logic                         r_en,
    output logic [DATA_SIZE-1:0]         r_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(FIFO_DEPTH):0]  free_cnt
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       used_c;
    logic                 do_push_c, do_pop_c;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign used_c    = wr_ptr_q - rd_ptr_q;
    assign free_cnt  = (PTR_W+1)'(FIFO_DEPTH) - used_c;
    assign r_data    = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign do_push_c = w_en && !full && !flush;
    assign do_pop_c  = r_en && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push_c) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            if (do_pop_c)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q[PTR_W-1:0]] <= w_data;
    end

endmodule

// File: rtl/instr_dispatch_nc.sv
// N-core fetch/dispatch: owns the fetch PC, issues reads, routes returned words
// into per-core FIFOs and applies fixed-priority branches with a global flush.
module instr_dispatch_nc
    import dispatch_pkg::*;
#(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned ADDR_SIZE  = 11,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ROUTE_MODE = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            mem_r_en,
    output logic [ADDR_SIZE-1:0]            mem_radrs,
    input  logic                            mem_r_valid,
    input  logic [DATA_SIZE-1:0]            mem_r_data,
    input  logic [NUM_CORES-1:0]            branch_valid,
    input  logic [NUM_CORES*ADDR_SIZE-1:0]  branch_address,
    input  logic [NUM_CORES-1:0]            fifo_r_en,
    output logic [NUM_CORES*DATA_SIZE-1:0]  fifo_r_data,
    output logic [NUM_CORES-1:0]            fifo_empty,
    output logic [NUM_CORES-1:0]            fifo_full,
    output logic [ADDR_SIZE-1:0]            pc,
    output logic                            branch_taken,
    output logic [$clog2(NUM_CORES)-1:0]    branch_src,
    output logic                            drop_pulse
);
    localparam int unsigned CID_W  = cid_width(NUM_CORES);
    localparam int unsigned FREE_W = $clog2(FIFO_DEPTH) + 1;
    localparam route_mode_e MODE   = route_mode_e'(ROUTE_MODE[0]);

    logic [ADDR_SIZE-1:0] pc_q, pc_d;
    logic [CID_W-1:0]     rr_q, rr_d;
    logic [CID_W-1:0]     src_q, src_d;
    logic                 issued_q;
    logic                 flush_pend_q, flush_pend_d;
    logic                 taken_q;
    logic                 drop_q, drop_d;

    logic                 branch_any_c, room_c, discard_c, dest_ok_c, push_c;
    logic [CID_W-1:0]     win_c, dest_c;
    logic [ADDR_SIZE-1:0] target_c;
    logic [FREE_W-1:0]    free_cnt_c [NUM_CORES];
    logic [NUM_CORES-1:0] fifo_w_en_c;

    // Lowest-index branch request wins.
    always_comb begin
        win_c    = '0;
        target_c = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (branch_valid[i]) begin
                win_c    = CID_W'(i);
                target_c = branch_address[i*ADDR_SIZE +: ADDR_SIZE];
            end
        end
    end

    // Two free slots per FIFO: one for the read in flight, one for this issue.
    always_comb begin
        room_c = 1'b1;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (free_cnt_c[i] < FREE_W'(2)) room_c = 1'b0;
        end
    end

    assign branch_any_c = |branch_valid;
    assign mem_r_en     = !rst && !branch_any_c && room_c;
    assign discard_c    = branch_any_c || flush_pend_q;
    assign dest_c       = (MODE == ROUTE_RR) ? rr_q : mem_r_data[DATA_SIZE-1 -: CID_W];
    assign dest_ok_c    = 32'(dest_c) < NUM_CORES;
    assign push_c       = mem_r_valid && !discard_c && dest_ok_c;

    always_comb begin
        fifo_w_en_c = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            fifo_w_en_c[i] = push_c && (dest_c == CID_W'(i));
        end
    end

    always_comb begin
        pc_d         = pc_q;
        rr_d         = rr_q;
        src_d        = src_q;
        flush_pend_d = branch_any_c && issued_q;
        drop_d       = mem_r_valid && (discard_c || !dest_ok_c);
        if (branch_any_c) begin
            pc_d  = target_c;
            src_d = win_c;
            rr_d  = '0;
        end else begin
            if (mem_r_en) pc_d = pc_q + ADDR_SIZE'(1);
            if (push_c && (MODE == ROUTE_RR)) begin
                rr_d = (32'(rr_q) == NUM_CORES - 1) ? '0 : rr_q + CID_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= '0;
            rr_q         <= '0;
            src_q        <= '0;
            issued_q     <= 1'b0;
            flush_pend_q <= 1'b0;
            taken_q      <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            rr_q         <= rr_d;
            src_q        <= src_d;
            issued_q     <= mem_r_en;
            flush_pend_q <= flush_pend_d;
            taken_q      <= branch_any_c;
            drop_q       <= drop_d;
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_fifo
        sync_fifo #(
            .DATA_SIZE  (DATA_SIZE),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .flush    (branch_any_c),
            .w_en     (fifo_w_en_c[g]),
            .w_data   (mem_r_data),
            .r_en     (fifo_r_en[g]),
            .r_data   (fifo_r_data[g*DATA_SIZE +: DATA_SIZE]),
            .empty    (fifo_empty[g]),
            .full     (fifo_full[g]),
            .free_cnt (free_cnt_c[g])
        );
    end

    assign mem_radrs    = pc_q;
    assign pc           = pc_q;
    assign branch_taken = taken_q;
    assign branch_src   = src_q;
    assign drop_pulse   = drop_q;

endmodule

// File: tb/tb_instr_dispatch_nc.sv
// Randomized bench: two 3-core instances (tag and round-robin routing) against a queue-level model.
module tb_instr_dispatch_nc;
    localparam int NC = 3;
    localparam int DS = 32;
    localparam int AS = 11;
    localparam int FD = 4;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic rst;
    logic [NC-1:0]    bv;
    logic [NC*AS-1:0] ba;
    logic [NC-1:0]    fre;

    logic          mem_r_en    [2];
    logic [AS-1:0] mem_radrs   [2];
    logic          mem_r_valid [2];
    logic [DS-1:0] mem_r_data  [2];
    logic [NC*DS-1:0] frd      [2];
    logic [NC-1:0] fe [2];
    logic [NC-1:0] ff [2];
    logic [AS-1:0] pcv [2];
    logic          tk  [2];
    logic [1:0]    src [2];
    logic          drp [2];

    logic [DS-1:0] mem [2048];

    int n_vec = 0;
    int n_err = 0;

    // Model state: index 0 = tag routing, 1 = round-robin
    int          m_pc   [2];
    int          m_cnt  [2][NC];
    logic [31:0] m_q    [2][NC][FD];
    int          m_rr   [2];
    bit          m_iss  [2];
    logic [31:0] m_dat  [2];
    bit          m_tk   [2];
    int          m_src  [2];
    bit          m_drop [2];

    always #5 clk = ~clk;

    instr_dispatch_nc #(.NUM_CORES(NC), .DATA_SIZE(DS), .ADDR_SIZE(AS),
                        .FIFO_DEPTH(FD), .ROUTE_MODE(0)) u_dut_tag (
        .clk(clk), .rst(rst),
        .mem_r_en(mem_r_en[0]), .mem_radrs(mem_radrs[0]),
        .mem_r_valid(mem_r_valid[0]), .mem_r_data(mem_r_data[0]),
        .branch_valid(bv), .branch_address(ba), .fifo_r_en(fre),
        .fifo_r_data(frd[0]), .fifo_empty(fe[0]), .fifo_full(ff[0]),
        .pc(pcv[0]), .branch_taken(tk[0]), .branch_src(src[0]), .drop_pulse(drp[0])
    );

    instr_dispatch_nc #(.NUM_CORES(NC), .DATA_SIZE(DS), .ADDR_SIZE(AS),
                        .FIFO_DEPTH(FD), .ROUTE_MODE(1)) u_dut_rr (
        .clk(clk), .rst(rst),
        .mem_r_en(mem_r_en[1]), .mem_radrs(mem_radrs[1]),
        .mem_r_valid(mem_r_valid[1]), .mem_r_data(mem_r_data[1]),
        .branch_valid(bv), .branch_address(ba), .fifo_r_en(fre),
        .fifo_r_data(frd[1]), .fifo_empty(fe[1]), .fifo_full(ff[1]),
        .pc(pcv[1]), .branch_taken(tk[1]), .branch_src(src[1]), .drop_pulse(drp[1])
    );

    // Instruction memory: answers one cycle after each read request.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            mem_r_valid[d] <= mem_r_en[d];
            mem_r_data[d]  <= mem[mem_radrs[d]];
        end
    end

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        m_pc[d] = 0; m_rr[d] = 0; m_iss[d] = 0; m_dat[d] = '0;
        m_tk[d] = 0; m_src[d] = 0; m_drop[d] = 0;
        for (int c = 0; c < NC; c++) m_cnt[d][c] = 0;
    endtask

    function automatic bit exp_en(input int d);
        if (rst || bv != '0) return 1'b0;
        for (int c = 0; c < NC; c++) if (FD - m_cnt[d][c] < 2) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_dut(input int d);
        chk($sformatf("pc[%0d]", d), 96'(pcv[d]), 96'(m_pc[d]));
        chk($sformatf("radrs[%0d]", d), 96'(mem_radrs[d]), 96'(m_pc[d]));
        chk($sformatf("r_en[%0d]", d), 96'(mem_r_en[d]), 96'(exp_en(d)));
        chk($sformatf("taken[%0d]", d), 96'(tk[d]), 96'(m_tk[d]));
        chk($sformatf("src[%0d]", d), 96'(src[d]), 96'(m_src[d]));
        chk($sformatf("drop[%0d]", d), 96'(drp[d]), 96'(m_drop[d]));
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("empty[%0d][%0d]", d, c), 96'(fe[d][c]), 96'(m_cnt[d][c] == 0));
            chk($sformatf("full[%0d][%0d]", d, c), 96'(ff[d][c]), 96'(m_cnt[d][c] == FD));
            if (m_cnt[d][c] > 0)
                chk($sformatf("head[%0d][%0d]", d, c), 96'(frd[d][c*DS +: DS]), 96'(m_q[d][c][0]));
        end
    endtask

    // Advance the model across one clock edge using the currently driven inputs.
    task automatic model_step(input int d);
        bit          iss, vld;
        logic [31:0] w;
        int          dest, win;
        iss = exp_en(d);
        if (rst) begin
            model_reset(d);
            return;
        end
        vld      = m_iss[d];
        w        = m_dat[d];
        m_iss[d] = iss;
        m_dat[d] = mem[m_pc[d]];
        m_drop[d] = 0;
        if (bv != '0) begin
            win = 0;
            while (!bv[win]) win++;
            m_pc[d]  = int'(ba[win*AS +: AS]);
            m_src[d] = win;
            m_tk[d]  = 1;
            m_rr[d]  = 0;
            m_drop[d] = vld;
            for (int c = 0; c < NC; c++) m_cnt[d][c] = 0;
        end else begin
            m_tk[d] = 0;
            for (int c = 0; c < NC; c++) begin
                if (fre[c] && m_cnt[d][c] > 0) begin
                    for (int k = 0; k < FD - 1; k++) m_q[d][c][k] = m_q[d][c][k+1];
                    m_cnt[d][c]--;
                end
            end
            if (vld) begin
                dest = (d == 1) ? m_rr[d] : int'(w[31:30]);
                if (dest >= NC) begin
                    m_drop[d] = 1;
                end else if (m_cnt[d][dest] < FD) begin
                    m_q[d][dest][m_cnt[d][dest]] = w;
                    m_cnt[d][dest]++;
                    if (d == 1) m_rr[d] = (m_rr[d] + 1) % NC;
                end
            end
            if (iss) m_pc[d] = (m_pc[d] + 1) % 2048;
        end
    endtask

    function automatic logic [AS-1:0] pick_target();
        case ($urandom_range(0, 3))
            0:       return 11'h7FF;
            1:       return 11'h7FE;
            2:       return 11'h000;
            default: return 11'($urandom);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        rst = 1'b1;
        bv  = '0;
        ba  = '0;
        fre = '0;
        repeat (2) @(posedge clk);
        model_reset(0);
        model_reset(1);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            rst = (cyc > 80) && ($urandom_range(0, 299) == 0);
            for (int c = 0; c < NC; c++) ba[c*AS +: AS] = pick_target();
            if (cyc < 60) begin
                bv  = '0;
                fre = '0;
            end else begin
                bv  = ($urandom_range(0, 9) == 0) ? NC'($urandom_range(1, 7)) : '0;
                fre = NC'($urandom);
                if (((cyc / 200) % 2) == 1) fre = fre & NC'($urandom) & NC'($urandom);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                check_dut(d);
                model_step(d);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
